// File: rtl/fabric_fle_pkg.sv
// rtl/fabric_fle_pkg.sv - shared loader state type and configuration layout helpers
// Purpose: loader FSM encoding plus sizing/offset arithmetic for the FLE config image.
// Ports: none (package).
package fabric_fle_pkg;

  typedef enum logic [1:0] {
    LDR_IDLE = 2'd0,
    LDR_LOAD = 2'd1,
    LDR_DONE = 2'd2
  } ldr_state_e;

  // Bits of configuration owned by one element: LUT mask plus four control bits.
  function automatic int fle_cfg_w(input int lut_k);
    return (1 << lut_k) + 4;
  endfunction

  function automatic int fle_cfg_nwords(input int num_fle, input int lut_k, input int cfg_word);
    return (num_fle * fle_cfg_w(lut_k) + cfg_word - 1) / cfg_word;
  endfunction

  // Control-bit offsets inside one element's slice; they follow the LUT mask.
  function automatic int fle_off_sel0(input int lut_k);
    return 1 << lut_k;
  endfunction

  function automatic int fle_off_sel1(input int lut_k);
    return (1 << lut_k) + 1;
  endfunction

  function automatic int fle_off_byp0(input int lut_k);
    return (1 << lut_k) + 2;
  endfunction

  function automatic int fle_off_byp1(input int lut_k);
    return (1 << lut_k) + 3;
  endfunction

endpackage

// File: rtl/fabric_fle_slice.sv
// rtl/fabric_fle_slice.sv - one fracturable logic element: LUT, carry bit, two scan flops
// Purpose: K-input LUT split into two (K-1)-input halves, one-bit adder, two flip-flops
//          with D-select and bypass, threaded on the cluster scan chain.
// Ports: clk/reset (sync, active-high); ff_clr clears both flops; cfg is this element's
//        config slice; lut_in/cin are combinational inputs; ld_en loads D; scan_en/sc_in
//        shift the chain; o6/cout/out are raw (ungated) outputs; sc_out is Q of FF1.
module fabric_fle_slice
  import fabric_fle_pkg::*;
#(
  parameter int LUT_K = 6,
  localparam int CFG_W = fle_cfg_w(LUT_K)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ff_clr,
  input  logic [CFG_W-1:0] cfg,
  input  logic [LUT_K-1:0] lut_in,
  input  logic             cin,
  input  logic             ld_en,
  input  logic             scan_en,
  input  logic             sc_in,
  output logic             o6,
  output logic             cout,
  output logic [1:0]       out,
  output logic             sc_out
);

  localparam int HALF = 1 << (LUT_K - 1);

  logic [HALF-1:0] mask_lo;
  logic [HALF-1:0] mask_hi;
  logic            lut5_0;
  logic            lut5_1;
  logic            sum;
  logic [1:0]      d_sel;
  logic [1:0]      ff_d;
  logic [1:0]      ff_q;

  assign mask_lo = cfg[HALF-1:0];
  assign mask_hi = cfg[2*HALF-1:HALF];

  assign lut5_0 = mask_lo[lut_in[LUT_K-2:0]];
  assign lut5_1 = mask_hi[lut_in[LUT_K-2:0]];
  assign o6     = lut_in[LUT_K-1] ? lut5_1 : lut5_0;

  // Lower half acts as propagate, upper half as generate.
  assign sum  = lut5_0 ^ cin;
  assign cout = lut5_0 ? cin : lut5_1;

  assign d_sel[0] = cfg[fle_off_sel0(LUT_K)] ? sum : lut5_0;
  assign d_sel[1] = cfg[fle_off_sel1(LUT_K)] ? o6  : lut5_1;

  // Scan outranks functional load; chain order inside the element is FF0 then FF1.
  always_comb begin
    ff_d = ff_q;
    if (ff_clr) begin
      ff_d = '0;
    end else if (scan_en) begin
      ff_d = {ff_q[0], sc_in};
    end else if (ld_en) begin
      ff_d = d_sel;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ff_q <= '0;
    end else begin
      ff_q <= ff_d;
    end
  end

  assign out[0] = cfg[fle_off_byp0(LUT_K)] ? d_sel[0] : ff_q[0];
  assign out[1] = cfg[fle_off_byp1(LUT_K)] ? d_sel[1] : ff_q[1];
  assign sc_out = ff_q[1];

endmodule

// File: rtl/fabric_fle_cluster.sv
// rtl/fabric_fle_cluster.sv - cluster of fracturable logic elements with word-serial config loader
// Purpose: holds the configuration register array and its loader FSM, chains carry and
//          scan across NUM_FLE slices, and gates outputs until configuration is complete.
// Ports: fabric_clk/fabric_reset (sync, active-high); cfg_start/cfg_valid/cfg_ready/
//        cfg_data/cfg_done form the loader handshake; scan_en/fabric_sc_in/fabric_sc_out
//        is the flop scan chain; fabric_in/fabric_enable/fabric_cin feed the elements;
//        fabric_out/fabric_o6/fabric_cout are the gated element outputs.
module fabric_fle_cluster
  import fabric_fle_pkg::*;
#(
  parameter int NUM_FLE  = 4,
  parameter int LUT_K    = 6,
  parameter int CFG_WORD = 8
) (
  input  logic                       fabric_clk,
  input  logic                       fabric_reset,
  input  logic                       cfg_start,
  input  logic                       cfg_valid,
  output logic                       cfg_ready,
  input  logic [CFG_WORD-1:0]        cfg_data,
  output logic                       cfg_done,
  input  logic                       scan_en,
  input  logic                       fabric_sc_in,
  output logic                       fabric_sc_out,
  input  logic [NUM_FLE*LUT_K-1:0]   fabric_in,
  input  logic [NUM_FLE-1:0]         fabric_enable,
  input  logic                       fabric_cin,
  output logic [2*NUM_FLE-1:0]       fabric_out,
  output logic [NUM_FLE-1:0]         fabric_o6,
  output logic                       fabric_cout
);

  localparam int CFG_W      = fle_cfg_w(LUT_K);
  localparam int CFG_TOTAL  = NUM_FLE * CFG_W;
  localparam int CFG_NWORDS = fle_cfg_nwords(NUM_FLE, LUT_K, CFG_WORD);
  localparam int WCNT_W     = $clog2(CFG_NWORDS + 1);
  localparam logic [WCNT_W-1:0] LAST_WORD = WCNT_W'(CFG_NWORDS - 1);

  ldr_state_e           state_d, state_q;
  logic [WCNT_W-1:0]    wcnt_d, wcnt_q;
  logic [CFG_TOTAL-1:0] cfg_mem_d, cfg_mem_q;
  logic                 ff_clr;
  logic [NUM_FLE-1:0]   o6_raw;
  logic [2*NUM_FLE-1:0] out_raw;
  logic                 cout_raw;

  always_comb begin
    state_d   = state_q;
    wcnt_d    = wcnt_q;
    cfg_mem_d = cfg_mem_q;
    ff_clr    = 1'b0;
    case (state_q)
      LDR_LOAD: begin
        // A restart inside LOAD only rewinds the counter; the word on cfg_data is dropped.
        if (cfg_start) begin
          wcnt_d = '0;
        end else if (cfg_valid) begin
          // Bits of the final word that fall past CFG_TOTAL have no home and are dropped.
          for (int b = 0; b < CFG_TOTAL; b++) begin
            if (b / CFG_WORD == int'(wcnt_q)) begin
              cfg_mem_d[b] = cfg_data[b % CFG_WORD];
            end
          end
          wcnt_d = wcnt_q + 1'b1;
          if (wcnt_q == LAST_WORD) begin
            state_d = LDR_DONE;
          end
        end
      end
      default: begin
        if (cfg_start) begin
          state_d = LDR_LOAD;
          wcnt_d  = '0;
          ff_clr  = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge fabric_clk) begin
    if (fabric_reset) begin
      state_q   <= LDR_IDLE;
      wcnt_q    <= '0;
      cfg_mem_q <= '0;
    end else begin
      state_q   <= state_d;
      wcnt_q    <= wcnt_d;
      cfg_mem_q <= cfg_mem_d;
    end
  end

  assign cfg_ready = (state_q == LDR_LOAD);
  assign cfg_done  = (state_q == LDR_DONE);

  // Per-element link signals keep the ripple carry and scan chain as distinct nets.
  for (genvar i = 0; i < NUM_FLE; i++) begin : g_fle
    logic cin_i;
    logic sc_in_i;
    logic cout_i;
    logic sc_out_i;

    if (i == 0) begin : g_head
      assign cin_i   = fabric_cin;
      assign sc_in_i = fabric_sc_in;
    end else begin : g_link
      assign cin_i   = g_fle[i-1].cout_i;
      assign sc_in_i = g_fle[i-1].sc_out_i;
    end

    fabric_fle_slice #(
      .LUT_K(LUT_K)
    ) u_slice (
      .clk     (fabric_clk),
      .reset   (fabric_reset),
      .ff_clr  (ff_clr),
      .cfg     (cfg_mem_q[i*CFG_W +: CFG_W]),
      .lut_in  (fabric_in[i*LUT_K +: LUT_K]),
      .cin     (cin_i),
      .ld_en   (cfg_done & fabric_enable[i]),
      .scan_en (scan_en),
      .sc_in   (sc_in_i),
      .o6      (o6_raw[i]),
      .cout    (cout_i),
      .out     (out_raw[2*i +: 2]),
      .sc_out  (sc_out_i)
    );
  end

  assign cout_raw      = g_fle[NUM_FLE-1].cout_i;
  assign fabric_sc_out = g_fle[NUM_FLE-1].sc_out_i;

  // Half-written configuration must never reach the routing.
  assign fabric_out  = cfg_done ? out_raw  : '0;
  assign fabric_o6   = cfg_done ? o6_raw   : '0;
  assign fabric_cout = cfg_done ? cout_raw : 1'b0;

endmodule
